// File: rtl/bridge_pkg.sv
// Shared AHB transfer-type encodings and arbiter state type for the AHB-to-APB bridge slice.
package bridge_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_DEFAULT,
        ST_OWNED,
        ST_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request after index last_i, wrapping.
module rr_priority_picker #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MW-1:0]          last_i,
    output logic [MW-1:0]          winner_o,
    output logic                   valid_o
);

    int unsigned idx;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        // Offsets 1..NUM_MASTERS so the previous winner is checked last.
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = (32'(last_i) + i) % NUM_MASTERS;
            if (!valid_o && req_i[idx]) begin
                winner_o = MW'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter in front of the bridge slave port; grants move only at
// transfer boundaries. Define ARB_LOCK_EN to honour hlock (locked sequences).
module ahb_bus_arbiter
    import bridge_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_data,
    output logic                   hmastlock
);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          last_q, last_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [MW-1:0]          hmaster_data_q, hmaster_data_d;
    logic                   hmastlock_q, hmastlock_d;

    logic [MW-1:0] owner;
    logic [MW-1:0] winner;
    logic          win_valid;
    logic          owner_lock;
    logic          win_lock;
    logic          hold;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_picker (
        .req_i    (hbusreq),
        .last_i   (last_q),
        .winner_o (winner),
        .valid_o  (win_valid)
    );

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                owner = MW'(i);
            end
        end
    end

`ifdef ARB_LOCK_EN
    assign owner_lock = hlock[owner];
    assign win_lock   = hlock[winner];
`else
    logic unused_hlock;
    assign unused_hlock = ^hlock;
    assign owner_lock   = 1'b0;
    assign win_lock     = 1'b0;
`endif

    // BUSY and SEQ both have htrans[0] set: never split a burst mid-flight.
    assign hold = htrans[0] || ((state_q == ST_LOCKED) && owner_lock);

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        hmaster_d      = hmaster_q;
        hmaster_data_d = hmaster_data_q;
        hmastlock_d    = hmastlock_q;
        if (hready) begin
            hmaster_d      = owner;
            hmaster_data_d = hmaster_q;
            hmastlock_d    = owner_lock;
            if (!hold) begin
                if (win_valid) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    last_d          = winner;
                    state_d         = win_lock ? ST_LOCKED : ST_OWNED;
                end else begin
                    grant_d = NUM_MASTERS'(1);
                    state_d = ST_DEFAULT;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q        <= ST_DEFAULT;
            grant_q        <= NUM_MASTERS'(1);
            last_q         <= MW'(NUM_MASTERS - 1);
            hmaster_q      <= '0;
            hmaster_data_q <= '0;
            hmastlock_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_q         <= last_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hmastlock_q    <= hmastlock_d;
        end
    end

    assign hgrant       = grant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign hmastlock    = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed vector bench for ahb_bus_arbiter (4 masters); lock sequence runs when ARB_LOCK_EN is set.
module tb_ahb_bus_arbiter;
    import bridge_pkg::*;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic [3:0] hbusreq = 4'b0000;
    logic [3:0] hlock = 4'b0000;
    logic [1:0] htrans = HTRANS_IDLE;
    logic       hready = 1'b1;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    ahb_bus_arbiter #(
        .NUM_MASTERS (4),
        .MW          (2)
    ) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .hbusreq      (hbusreq),
        .hlock        (hlock),
        .htrans       (htrans),
        .hready       (hready),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hmastlock    (hmastlock)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] trans;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] hm;
        logic [1:0] hmd;
        logic [1:0] last;
        arb_state_e st;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] req, input logic [1:0] trans, input logic rdy,
                       input logic [3:0] grant, input logic [1:0] hm, input logic [1:0] hmd,
                       input logic [1:0] last, input arb_state_e st);
        vec_t v;
        v.req = req; v.trans = trans; v.rdy = rdy; v.grant = grant;
        v.hm = hm; v.hmd = hmd; v.last = last; v.st = st;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] req, input logic [1:0] trans, input logic rdy,
                        input logic [3:0] lk);
        hbusreq = req;
        htrans  = trans;
        hready  = rdy;
        hlock   = lk;
        @(posedge hclk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " hgrant"}, 32'(hgrant), 32'h1);
        check({tag, " hmaster"}, 32'(hmaster), 32'h0);
        check({tag, " hmaster_data"}, 32'(hmaster_data), 32'h0);
        check({tag, " hmastlock"}, 32'(hmastlock), 32'h0);
        check({tag, " last"}, 32'(dut.last_q), 32'h3);
        check({tag, " state"}, 32'(dut.state_q), 32'(ST_DEFAULT));
    endtask

    always @(negedge hclk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot(hgrant)) begin
                errors++;
                $display("FAIL onehot hgrant: got %b expected exactly one bit", hgrant);
            end
        end
    end

    initial begin
        // Rotation, burst hold, wait states, idle default, owner dropping request mid-burst.
        add(4'b1111, HTRANS_IDLE,   1'b1, 4'b0001, 2'd0, 2'd0, 2'd0, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0, 2'd0, 2'd1, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd1, 2'd0, 2'd2, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd2, 2'd1, 2'd3, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd3, 2'd2, 2'd0, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0, 2'd3, 2'd1, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd1, 2'd0, 2'd2, ST_OWNED);
        add(4'b1111, HTRANS_SEQ,    1'b1, 4'b0100, 2'd2, 2'd1, 2'd2, ST_OWNED);
        add(4'b1111, HTRANS_SEQ,    1'b1, 4'b0100, 2'd2, 2'd2, 2'd2, ST_OWNED);
        add(4'b1111, HTRANS_SEQ,    1'b1, 4'b0100, 2'd2, 2'd2, 2'd2, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b1000, 2'd2, 2'd2, 2'd3, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd2, 2'd2, 2'd3, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd2, 2'd2, 2'd3, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b0, 4'b1000, 2'd2, 2'd2, 2'd3, ST_OWNED);
        add(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd3, 2'd2, 2'd0, ST_OWNED);
        add(4'b0010, HTRANS_NONSEQ, 1'b1, 4'b0010, 2'd0, 2'd3, 2'd1, ST_OWNED);
        add(4'b0000, HTRANS_IDLE,   1'b1, 4'b0001, 2'd1, 2'd0, 2'd1, ST_DEFAULT);
        add(4'b1001, HTRANS_IDLE,   1'b1, 4'b1000, 2'd0, 2'd1, 2'd3, ST_OWNED);
        add(4'b0000, HTRANS_IDLE,   1'b1, 4'b0001, 2'd3, 2'd0, 2'd3, ST_DEFAULT);
        add(4'b0100, HTRANS_NONSEQ, 1'b1, 4'b0100, 2'd0, 2'd3, 2'd2, ST_OWNED);
        add(4'b0000, HTRANS_SEQ,    1'b1, 4'b0100, 2'd2, 2'd0, 2'd2, ST_OWNED);
        add(4'b0000, HTRANS_BUSY,   1'b1, 4'b0100, 2'd2, 2'd2, 2'd2, ST_OWNED);
        add(4'b0000, HTRANS_IDLE,   1'b1, 4'b0001, 2'd2, 2'd2, 2'd2, ST_DEFAULT);
        add(4'b0001, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd0, 2'd2, 2'd0, ST_OWNED);
        add(4'b0001, HTRANS_NONSEQ, 1'b1, 4'b0001, 2'd0, 2'd0, 2'd0, ST_OWNED);

        // Reset held with every master requesting.
        hbusreq = 4'b1111;
        htrans  = HTRANS_NONSEQ;
        repeat (3) @(posedge hclk);
        #1;
        check_reset_values("reset");
        mon_en  = 1'b1;
        hresetn = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].req, vq[i].trans, vq[i].rdy, 4'b0000);
            check($sformatf("vec%0d hgrant", i), 32'(hgrant), 32'(vq[i].grant));
            check($sformatf("vec%0d hmaster", i), 32'(hmaster), 32'(vq[i].hm));
            check($sformatf("vec%0d hmaster_data", i), 32'(hmaster_data), 32'(vq[i].hmd));
            check($sformatf("vec%0d hmastlock", i), 32'(hmastlock), 32'h0);
            check($sformatf("vec%0d last", i), 32'(dut.last_q), 32'(vq[i].last));
            check($sformatf("vec%0d state", i), 32'(dut.state_q), 32'(vq[i].st));
        end

        // Reset asserted in the middle of a burst takes effect without a clock edge.
        step(4'b1111, HTRANS_NONSEQ, 1'b1, 4'b0000);
        check("midrst pre hgrant", 32'(hgrant), 32'b0010);
        step(4'b1111, HTRANS_SEQ, 1'b1, 4'b0000);
        hresetn = 1'b0;
        #1;
        check_reset_values("midrst");
        step(4'b0000, HTRANS_IDLE, 1'b1, 4'b0000);
        hresetn = 1'b1;
        step(4'b0000, HTRANS_IDLE, 1'b1, 4'b0000);
        check("post-rst hgrant", 32'(hgrant), 32'b0001);
        check("post-rst last", 32'(dut.last_q), 32'h3);

`ifdef ARB_LOCK_EN
        // Master 1 locks the bus for four transfers while master 3 waits.
        step(4'b1010, HTRANS_NONSEQ, 1'b1, 4'b0010);
        check("lock0 hgrant", 32'(hgrant), 32'b0010);
        check("lock0 state", 32'(dut.state_q), 32'(ST_LOCKED));
        for (int k = 1; k <= 4; k++) begin
            step(4'b1010, HTRANS_NONSEQ, 1'b1, 4'b0010);
            check($sformatf("lock%0d hgrant", k), 32'(hgrant), 32'b0010);
            check($sformatf("lock%0d hmastlock", k), 32'(hmastlock), 32'h1);
        end
        step(4'b1010, HTRANS_NONSEQ, 1'b1, 4'b0000);
        check("unlock hgrant", 32'(hgrant), 32'b1000);
        check("unlock hmastlock", 32'(hmastlock), 32'h0);
        check("unlock state", 32'(dut.state_q), 32'(ST_OWNED));
`else
        // Without lock support hlock must not stall hand-over.
        step(4'b1010, HTRANS_NONSEQ, 1'b1, 4'b0010);
        check("nolock0 hgrant", 32'(hgrant), 32'b0010);
        step(4'b1010, HTRANS_NONSEQ, 1'b1, 4'b0010);
        check("nolock1 hgrant", 32'(hgrant), 32'b1000);
        check("nolock1 hmastlock", 32'(hmastlock), 32'h0);
`endif

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
